// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide synchronous-read RAM between the
// 10-byte instruction fetch port and the 8-byte data port. Each access is
// serialised into little-endian byte cycles and out-of-range accesses are
// rejected without touching the RAM.
//
// state | meaning
// IDLE  | no RAM activity; arbitrate, latch fields, range-check
// ERR   | one-cycle error ack to the owner, rdata = 0
// XFER  | one RAM byte per cycle, k = 0..LEN-1
// DRAIN | RAM idle while the last read byte returns
// ACK   | one-cycle completion ack to the owner with assembled data
module mem_port_arbiter #(
  parameter int ADDR_LIMIT = 1024,
  parameter int RAM_AW     = 10
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [63:0]       d_addr_i,
  input  logic [63:0]       d_wdata_i,
  output logic              d_ack_o,
  output logic [63:0]       d_rdata_o,
  output logic              d_err_o,
  input  logic              f_req_i,
  input  logic [63:0]       f_addr_i,
  output logic              f_ack_o,
  output logic [79:0]       f_rdata_o,
  output logic              f_err_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i,
  output logic              busy_o,
  output logic              grant_o
);

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_XFER, S_DRAIN, S_ACK} state_t;

  // Highest legal start address per port; compared unsigned on the full
  // 64 bits so huge addresses cannot wrap into range.
  localparam logic [63:0] D_MAX = 64'(ADDR_LIMIT - 8);
  localparam logic [63:0] F_MAX = 64'(ADDR_LIMIT - 10);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_grant;   // owner of current/last transaction, also the round-robin pointer
  logic              r_we;
  logic [RAM_AW-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic [3:0]        r_k;
  logic [79:0]       r_asm;
  logic [63:0]       r_d_rdata;
  logic [79:0]       r_f_rdata;

  logic              w_any;
  logic              w_pick_d;
  logic              w_err;
  logic [3:0]        w_last_k;
  logic [3:0]        w_cap_k;
  logic              w_cap_en;
  logic [79:0]       w_asm_fin;

  // Arbitration and range check for the requester that would be granted now.
  always_comb begin
    w_any    = d_req_i | f_req_i;
    w_pick_d = d_req_i & (~f_req_i | ~r_grant);
    w_err    = w_pick_d ? (d_addr_i > D_MAX) : (f_addr_i > F_MAX);
    w_last_k = r_grant ? 4'd7 : 4'd9;
    w_cap_k  = r_k - 4'd1;
    w_cap_en = ((r_state == S_XFER) && (r_k != 4'd0)) || (r_state == S_DRAIN);
    w_asm_fin = r_asm;
    w_asm_fin[{w_cap_k, 3'b000} +: 8] = ram_rdata_i;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    d_ack_o     = 1'b0;
    d_err_o     = 1'b0;
    f_ack_o     = 1'b0;
    f_err_o     = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = 8'h00;
    case (r_state)
      S_IDLE: if (w_any) w_state_nxt = w_err ? S_ERR : S_XFER;
      S_ERR: begin
        d_ack_o     = r_grant;
        d_err_o     = r_grant;
        f_ack_o     = ~r_grant;
        f_err_o     = ~r_grant;
        w_state_nxt = S_IDLE;
      end
      S_XFER: begin
        ram_en_o    = 1'b1;
        ram_we_o    = r_we;
        ram_addr_o  = r_addr + RAM_AW'(r_k);
        ram_wdata_o = r_we ? r_wdata[{r_k[2:0], 3'b000} +: 8] : 8'h00;
        if (r_k == w_last_k) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: w_state_nxt = S_ACK;
      S_ACK: begin
        d_ack_o     = r_grant;
        f_ack_o     = ~r_grant;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant latch, byte counter, read assembly and registered read data.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_grant   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_k       <= '0;
      r_asm     <= '0;
      r_d_rdata <= '0;
      r_f_rdata <= '0;
    end else begin
      if (w_cap_en) r_asm <= w_asm_fin;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_grant <= w_pick_d;
          r_we    <= w_pick_d & d_we_i;
          r_addr  <= w_pick_d ? d_addr_i[RAM_AW-1:0] : f_addr_i[RAM_AW-1:0];
          r_wdata <= d_wdata_i;
          r_k     <= '0;
          r_asm   <= '0;
          if (w_err) begin
            if (w_pick_d) r_d_rdata <= '0;
            else          r_f_rdata <= '0;
          end
        end
        S_XFER: r_k <= r_k + 4'd1;
        S_DRAIN: begin
          if (r_grant) r_d_rdata <= r_we ? 64'h0 : w_asm_fin[63:0];
          else         r_f_rdata <= w_asm_fin;
        end
        default: ;
      endcase
    end
  end

  assign d_rdata_o = r_d_rdata;
  assign f_rdata_o = r_f_rdata;
  assign busy_o    = (r_state != S_IDLE);
  assign grant_o   = r_grant;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one byte-wide, single-port, synchronous-read data RAM between two requesters: instruction fetch (10-byte read-only) and memory access (8-byte read/write).
- Serialises each multi-byte access into per-byte RAM cycles in little-endian order, assembles read data, and flags out-of-range accesses without touching the RAM.
- Sits between the fetch/memory_access stages and the RAM macro.

Parameters:
ADDR_LIMIT, 1024, RAM size in bytes; valid byte addresses are 0..ADDR_LIMIT-1
RAM_AW, 10, RAM byte-address width (clog2 of ADDR_LIMIT)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_n_i  in  1  synchronous active-low reset
d_req_i  in  1  data request valid; held with fields stable until d_ack_o
d_we_i  in  1  1 = 8-byte write, 0 = 8-byte read
d_addr_i  in  64  data byte address (valE/valA from memory stage)
d_wdata_i  in  64  write data
d_ack_o  out  1  one-cycle completion pulse
d_rdata_o  out  64  read data, valid when d_ack_o is high
d_err_o  out  1  address error, valid when d_ack_o is high
f_req_i  in  1  fetch request valid; held stable until f_ack_o
f_addr_i  in  64  fetch byte address (PC)
f_ack_o  out  1  one-cycle completion pulse
f_rdata_o  out  80  10 instruction bytes, byte 0 in [7:0]
f_err_o  out  1  address error, valid when f_ack_o is high
ram_en_o  out  1  RAM byte access enable
ram_we_o  out  1  RAM byte write enable (only with ram_en_o)
ram_addr_o  out  RAM_AW  RAM byte address
ram_wdata_o  out  8  RAM write byte
ram_rdata_i  in  8  RAM read byte; valid the cycle after ram_en_o=1, ram_we_o=0
busy_o  out  1  high in any state other than IDLE
grant_o  out  1  owner of current/last transaction: 0 = fetch, 1 = data

Behaviour:
- Handshake: a transaction completes at the rising edge where req and ack are both high. The requester may present a new request in the following cycle. Address, we and wdata are latched at grant, so later changes are ignored. If req is dropped mid-transaction, the transaction still completes and acks.
- Arbitration happens in IDLE only.
  - One requester pending: it is granted.
  - Both pending: round-robin; the requester not granted last wins.
  - Pointer reset value makes data win the first tie.
- Length: LEN = 8 for data, 10 for fetch.
- Range check is done at grant: error iff addr > ADDR_LIMIT - LEN, as a 64-bit unsigned compare with no wrap.
  - Data: 1016 is OK, 1017 is an error.
  - Fetch: 1014 is OK, 1015 is an error.
- States: IDLE, ERR, XFER, DRAIN, ACK.
  - IDLE: no RAM activity. On grant, latch fields and set grant_o, clear byte counter k.
    - Range error -> ERR.
    - Otherwise -> XFER.
  - ERR (1 cycle): the owner's ack=1, err=1, rdata=0. No RAM access. -> IDLE.
  - XFER (LEN cycles, k = 0..LEN-1):
    - ram_en_o=1, ram_addr_o = addr[RAM_AW-1:0] + k, ram_we_o = we.
    - ram_wdata_o = wdata[8k+7:8k].
    - For reads, the byte returned for k-1 is captured into assembly register byte k-1.
    - After k = LEN-1 -> DRAIN.
  - DRAIN (1 cycle): ram_en_o=0. Last read byte captured. -> ACK.
  - ACK (1 cycle): owner ack=1, err=0.
    - Reads: rdata presents the assembled bytes.
    - Writes: d_rdata_o=0.
    - -> IDLE.
- Latency, with the grant in cycle 0:
  - Data read or write: ack in cycle 10.
  - Fetch: ack in cycle 12.
  - Error: ack in cycle 1.
  - Minimum spacing between back-to-back grants is one IDLE cycle.
- Outputs:
  - ack_o and err_o are high only in ERR/ACK and only for the owner.
  - rdata_o holds its last value outside ack; it is meaningful only with ack.
  - ram_* outputs are 0 outside XFER.
  - A fetch never drives ram_we_o=1.
- Reset: synchronous with rst_n_i=0.
  - State goes to IDLE.
  - All outputs go to 0, including grant_o=0, busy_o=0 and both rdata=0.
  - Round-robin pointer is set to "fetch last".
- Reset mid-XFER: takes effect at the next edge and no further bytes are issued. A partially written RAM word is left as is; this is accepted and no rollback is done.

Test Plan:
- Data write 0x0807060504030201 to addr 0, then data read addr 0 -> ram_we_o pulses for 8 cycles at addresses 0..7 with bytes 01..08; read acks in cycle 10 with d_rdata_o=0x0807060504030201, d_err_o=0.
- Fetch at 0x10 with RAM bytes 0x10..0x19 preloaded as 0xA0..0xA9 -> f_ack_o in cycle 12, f_rdata_o=0xA9A8A7A6A5A4A3A2A1A0, ram_we_o never high.
- Boundary: data read at 1016 -> OK; data at 1017 -> err in cycle 1 with no ram_en_o; fetch at 1014 -> OK; fetch at 1015 and data at 0xFFFFFFFFFFFFFFFF -> err, no wrap.
- d_req_i and f_req_i held high together for 4 transactions -> grants in order data, fetch, data, fetch; grant_o matches; one IDLE cycle between acks.
- rst_n_i=0 during the 4th byte of a data write -> next cycle busy_o=0, ram_en_o=0, no ack; RAM bytes 0..3 written, bytes 4..7 unchanged.
- d_req_i dropped and d_addr_i changed after grant -> transaction completes at the originally latched address; d_ack_o still pulses in cycle 10.
